// File: rtl/ll_head_table.sv
// ll_head_table -- linked-list head register with a write port and a
// latency-2 read request/response port.
//
// Contents of this file (compile order):
//   package linked_list   : HEAD_PTR_WIDTH
//   interface head_table_if: write port (master = list-update engine,
//                            slave = this block)
//   module ll_head_table   : the head register and read FSM
//
// Ports of ll_head_table:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   head_table           head_table_if.slave: wr_data_ptr, wr_data_ptr_val, wr_en
//   rd_req_i             read request
//   rd_req_ready_o       request can be accepted (FSM idle)
//   rd_valid_o           response valid
//   rd_ready_i           response consumed
//   rd_ptr_o             head pointer in the response
//   rd_ptr_val_o         head-valid flag in the response
//   head_upd_o           one-cycle pulse after each write
//   wr_cnt_o, rd_cnt_o   saturating write / accepted-read counters
//
// Build option: define LL_HEAD_TABLE_STATS_EN to build the counters;
// otherwise wr_cnt_o / rd_cnt_o are tied to 0.

package linked_list;
    parameter int HEAD_PTR_WIDTH = 8;
endpackage

interface head_table_if;
    logic [linked_list::HEAD_PTR_WIDTH-1:0] wr_data_ptr;
    logic                                   wr_data_ptr_val;
    logic                                   wr_en;

    modport master (output wr_data_ptr, output wr_data_ptr_val, output wr_en);
    modport slave  (input  wr_data_ptr, input  wr_data_ptr_val, input  wr_en);
endinterface

module ll_head_table
    import linked_list::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    head_table_if.slave               head_table,
    input  logic                      rd_req_i,
    output logic                      rd_req_ready_o,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [HEAD_PTR_WIDTH-1:0] rd_ptr_o,
    output logic                      rd_ptr_val_o,
    output logic                      head_upd_o,
    output logic [15:0]               wr_cnt_o,
    output logic [15:0]               rd_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIPE = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                      head_val;
    logic [HEAD_PTR_WIDTH-1:0] snap_ptr;
    logic                      snap_val;
    logic                      head_upd;
    logic                      accept;

    // An invalid head is always stored with a zero pointer so the response
    // never leaks stale pointer bits.
    logic [HEAD_PTR_WIDTH-1:0] wr_ptr_eff;
    assign wr_ptr_eff = head_table.wr_data_ptr_val ? head_table.wr_data_ptr
                                                   : '0;

    // ---------------- head register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_ptr <= '0;
            head_val <= 1'b0;
        end else if (head_table.wr_en) begin
            head_ptr <= wr_ptr_eff;
            head_val <= head_table.wr_data_ptr_val;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) head_upd <= 1'b0;
        else       head_upd <= head_table.wr_en;
    end

    assign head_upd_o = head_upd;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        rd_req_ready_o = 1'b0;
        rd_valid_o     = 1'b0;
        rd_ptr_o       = '0;
        rd_ptr_val_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                rd_req_ready_o = 1'b1;
                if (rd_req_i) begin
                    accept  = 1'b1;
                    state_d = PIPE;
                end
            end
            PIPE: state_d = RESP;
            RESP: begin
                rd_valid_o   = 1'b1;
                rd_ptr_o     = snap_ptr;
                rd_ptr_val_o = snap_val;
                if (rd_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot at acceptance with write-first forwarding; later writes
    // leave the pending response untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap_ptr <= '0;
            snap_val <= 1'b0;
        end else if (accept) begin
            if (head_table.wr_en) begin
                snap_ptr <= wr_ptr_eff;
                snap_val <= head_table.wr_data_ptr_val;
            end else begin
                snap_ptr <= head_ptr;
                snap_val <= head_val;
            end
        end
    end

    // ---------------- statistics ----------------
`ifdef LL_HEAD_TABLE_STATS_EN
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (head_table.wr_en && (wr_cnt != 16'hFFFF))
                wr_cnt <= wr_cnt + 16'd1;
            if (accept && (rd_cnt != 16'hFFFF))
                rd_cnt <= rd_cnt + 16'd1;
        end
    end

    assign wr_cnt_o = wr_cnt;
    assign rd_cnt_o = rd_cnt;
`else
    assign wr_cnt_o = 16'd0;
    assign rd_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_ll_head_table.sv
// tb_ll_head_table -- directed plus random bench for ll_head_table.
// A transaction-level model (head value, one pending read with an age in
// cycles, saturating counters) predicts every output each cycle.
module tb_ll_head_table;
    localparam int W = linked_list::HEAD_PTR_WIDTH;

    logic         clk;
    logic         rst;
    logic         rd_req;
    logic         rd_req_ready;
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_ptr;
    logic         rd_ptr_val;
    logic         head_upd;
    logic [15:0]  wr_cnt;
    logic [15:0]  rd_cnt;

    head_table_if hif ();

    ll_head_table dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .head_table     (hif),
        .rd_req_i       (rd_req),
        .rd_req_ready_o (rd_req_ready),
        .rd_valid_o     (rd_valid),
        .rd_ready_i     (rd_ready),
        .rd_ptr_o       (rd_ptr),
        .rd_ptr_val_o   (rd_ptr_val),
        .head_upd_o     (head_upd),
        .wr_cnt_o       (wr_cnt),
        .rd_cnt_o       (rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // ---------------- reference model ----------------
    int           m_head_ptr, m_head_val;
    bit           m_busy;        // a read is outstanding
    int           m_age;         // edges since acceptance
    int           m_snap_ptr, m_snap_val;
    bit           m_upd;
    int           m_wr_cnt, m_rd_cnt;

    function automatic void m_reset();
        m_head_ptr = 0; m_head_val = 0;
        m_busy = 0; m_age = 0;
        m_snap_ptr = 0; m_snap_val = 0;
        m_upd = 0; m_wr_cnt = 0; m_rd_cnt = 0;
    endfunction

    function automatic void m_cycle(bit we, int wp, bit wv, bit req, bit rdy);
        int new_ptr;
        new_ptr = wv ? wp : 0;
        m_upd = we;
        if (m_busy) begin
            if (m_age >= 2 && rdy) m_busy = 0;
            else if (m_age < 2) m_age++;
        end else if (req) begin
            m_busy = 1;
            m_age  = 1;
            m_snap_ptr = we ? new_ptr : m_head_ptr;
            m_snap_val = we ? int'(wv) : m_head_val;
            if (m_rd_cnt < 65535) m_rd_cnt++;
        end
        if (we) begin
            m_head_ptr = new_ptr;
            m_head_val = wv;
            if (m_wr_cnt < 65535) m_wr_cnt++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        bit vld;
        vld = m_busy && (m_age >= 2);
        chk({where, " ready"},    32'(rd_req_ready), 32'(!m_busy));
        chk({where, " valid"},    32'(rd_valid),     32'(vld));
        chk({where, " ptr"},      32'(rd_ptr),       vld ? 32'(m_snap_ptr) : 32'd0);
        chk({where, " ptr_val"},  32'(rd_ptr_val),   vld ? 32'(m_snap_val) : 32'd0);
        chk({where, " head_upd"}, 32'(head_upd),     32'(m_upd));
`ifdef LL_HEAD_TABLE_STATS_EN
        chk({where, " wr_cnt"},   32'(wr_cnt),       32'(m_wr_cnt));
        chk({where, " rd_cnt"},   32'(rd_cnt),       32'(m_rd_cnt));
`else
        chk({where, " wr_cnt"},   32'(wr_cnt),       32'd0);
        chk({where, " rd_cnt"},   32'(rd_cnt),       32'd0);
`endif
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance model.
    task automatic step(input string where, input bit we, input int wp, input bit wv,
                        input bit req, input bit rdy, input bit do_check);
        hif.wr_en           = we;
        hif.wr_data_ptr     = W'(wp);
        hif.wr_data_ptr_val = wv;
        rd_req              = req;
        rd_ready            = rdy;
        @(negedge clk);
        if (do_check) check_outputs(where);
        m_cycle(we, wp, wv, req, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        hif.wr_en = 1'b0; hif.wr_data_ptr = '0; hif.wr_data_ptr_val = 1'b0;
        rd_req = 1'b0; rd_ready = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("in_reset");
        rst = 1'b0;

        // first read after reset: empty head, latency 2
        step("rd0_acc", 0, 0, 0, 1, 1, 1);
        step("rd0_pipe", 0, 0, 0, 0, 1, 1);
        step("rd0_resp", 0, 0, 0, 0, 1, 1);
        step("rd0_idle", 0, 0, 0, 0, 1, 1);

        // plain write then read
        step("wr15", 1, 'h15, 1, 0, 1, 1);
        step("wr15_upd", 0, 0, 0, 0, 1, 1);
        step("rd1_acc", 0, 0, 0, 1, 1, 1);
        step("rd1_pipe", 0, 0, 0, 0, 1, 1);
        step("rd1_resp", 0, 0, 0, 0, 1, 1);
        step("rd1_idle", 0, 0, 0, 0, 1, 1);

        // write-first forwarding in the accept cycle
        step("fwd_acc", 1, 'h2A, 1, 1, 1, 1);
        step("fwd_pipe", 0, 0, 0, 0, 1, 1);
        step("fwd_resp", 0, 0, 0, 0, 1, 1);
        step("fwd_idle", 0, 0, 0, 0, 1, 1);

        // invalid write zeroes the pointer
        step("wr3f_inv", 1, 'h3F, 0, 0, 1, 1);
        step("rd2_acc", 0, 0, 0, 1, 1, 1);
        step("rd2_pipe", 0, 0, 0, 0, 1, 1);
        step("rd2_resp", 0, 0, 0, 0, 1, 1);
        step("rd2_idle", 0, 0, 0, 0, 1, 1);

        // backpressure with a write during PIPE and ignored requests
        step("bp_wrhead", 1, 'h33, 1, 0, 1, 1);
        step("bp_acc", 0, 0, 0, 1, 0, 1);
        step("bp_pipe_wr07", 1, 'h07, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            step("bp_hold", 0, 0, 0, i[0] == 1'b0, 0, 1);
        step("bp_hs_wr", 1, 'h11, 1, 1, 1, 1);   // write coincides with handshake
        step("bp_idle", 0, 0, 0, 0, 1, 1);
        step("bp_rd_acc", 0, 0, 0, 1, 1, 1);
        step("bp_rd_pipe", 0, 0, 0, 0, 1, 1);
        step("bp_rd_resp", 0, 0, 0, 0, 1, 1);

        // asynchronous reset while PIPE
        step("rst_pre_acc", 0, 0, 0, 1, 1, 1);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            step("rst_after", 0, 0, 0, 0, 1, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << W) - 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1);

        // counter saturation
        for (int i = 0; i < 70000; i++)
            step("sat_wr", 1, i & 'hFF, 1, 0, 1, 0);
        step("sat_chk0", 0, 0, 0, 0, 1, 1);
        step("sat_chk1", 0, 0, 0, 0, 1, 1);
        step("sat_wr_more", 1, 'h5A, 1, 0, 1, 1);
        step("sat_chk2", 0, 0, 0, 0, 1, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/ll_head_table.md
# ll_head_table

Slave end of `head_table_if`: the register that holds the linked-list head pointer and its valid flag. The list-update engine writes it through the interface's master modport. The traversal engine reads it through a request/response handshake with fixed two-cycle latency and output hold under backpressure. This block sits between those two engines and is the single source of truth for the list head.

## Interface

Parameters:
- None. The pointer width is `HEAD_PTR_WIDTH` from package `linked_list`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `head_table_if`  slave modport  —  write port.
  - `wr_data_ptr` [HEAD_PTR_WIDTH]: new head pointer.
  - `wr_data_ptr_val` [1]: new head is valid (list non-empty).
  - `wr_en` [1]: write strobe.
- `rd_req_i`  in  1  read request.
- `rd_req_ready_o`  out  1  request can be accepted.
- `rd_valid_o`  out  1  response valid.
- `rd_ready_i`  in  1  response consumed.
- `rd_ptr_o`  out  HEAD_PTR_WIDTH  head pointer in the response.
- `rd_ptr_val_o`  out  1  head-valid flag in the response.
- `head_upd_o`  out  1  one-cycle pulse after each accepted write.
- `wr_cnt_o`  out  16  write count (see Configuration).
- `rd_cnt_o`  out  16  read count (see Configuration).

## Operation

Write path:
- When `wr_en`=1, the block writes on the next edge: head_ptr ← `wr_data_ptr`, head_val ← `wr_data_ptr_val`.
- If `wr_data_ptr_val`=0, head_ptr is stored as 0 regardless of `wr_data_ptr`.
- Writes are always accepted. There is no backpressure on the interface.
- `head_upd_o` is registered. It is 1 in the cycle after each `wr_en` cycle. Back-to-back writes give a continuous high.

Read FSM (states IDLE, PIPE, RESP):
- IDLE: `rd_req_ready_o`=1.
  - A request is accepted when `rd_req_i`=1; the FSM goes to PIPE.
  - On acceptance, a snapshot is taken using write-first forwarding. If `wr_en`=1 in the same cycle, the snapshot takes the incoming write values, with the val=0 → ptr=0 rule applied. Otherwise it takes the stored head.
- PIPE: `rd_req_ready_o`=0. Goes unconditionally to RESP.
- RESP: `rd_valid_o`=1 and the snapshot is driven on `rd_ptr_o`/`rd_ptr_val_o`.
  - Outputs stay stable until `rd_ready_i`=1, then the FSM returns to IDLE.
- Writes that arrive after acceptance do not change a pending response.
- One read is outstanding at most.
- `rd_req_i` outside IDLE is ignored; it is not queued.

Reset values (asynchronous, also mid-operation): head_ptr=0, head_val=0, FSM=IDLE, `rd_req_ready_o`=1, `rd_valid_o`=0, `rd_ptr_o`=0, `rd_ptr_val_o`=0, `head_upd_o`=0, counters=0. An in-flight read is discarded.

## Timing

- Read latency: request accepted at cycle T → `rd_valid_o`=1 at T+2.
- Response handshake at cycle U → `rd_valid_o`=0 and `rd_req_ready_o`=1 at U+1.
- Minimum read period with `rd_ready_i` held high: 3 cycles.
- Write visibility:
  - A write at cycle T is visible to a request accepted at T, through forwarding.
  - It is also visible to any later request.
- `head_upd_o` latency: 1 cycle from `wr_en`.
- Simultaneous `wr_en` and response handshake: the write commits; the response shows the old snapshot.

## Configuration

- `LL_HEAD_TABLE_STATS_EN` defined:
  - `wr_cnt_o` increments on each `wr_en` cycle.
  - `rd_cnt_o` increments on each accepted read request.
  - Both are 16-bit, saturate at 0xFFFF (no wrap) and reset to 0.
- Undefined: no counter logic is built, and `wr_cnt_o`/`rd_cnt_o` are tied to 0. The port list is unchanged.

## Test plan

- Reset, then a read with `rd_ready_i`=1 → response at T+2 with ptr=0, val=0; `rd_req_ready_o` back high at T+3.
- Write ptr=0x15, val=1; then read → response ptr=0x15, val=1. `head_upd_o` is high exactly one cycle, at write+1.
- Write ptr=0x2A, val=1 in the same cycle a request is accepted (old head 0x15) → response ptr=0x2A. Write ptr=0x3F, val=0, then read → response ptr=0, val=0.
- Backpressure:
  - Hold `rd_ready_i`=0 for 5 cycles while writing 0x07 during PIPE.
  - Required: the response stays at the old snapshot and stable, and `rd_req_ready_o` stays 0.
  - Extra `rd_req_i` pulses are ignored: `rd_cnt_o` increments by 1 only with STATS_EN.
- Assert `rst_i` in PIPE → `rd_valid_o` stays 0, outputs clear immediately, and no response appears after release.
- With STATS_EN: 70000 writes → `wr_cnt_o`=0xFFFF, held. Without STATS_EN: both counters read 0 throughout.
